stack_ctrl_fsm: RTL and testbench

STACK_CTRL_FSM -- requirements
Module: stack_ctrl_fsm

---
 rtl/stack_ctrl_fsm.sv | 193 +++++++++++++++++++
 tb/tb_stack_ctrl_fsm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl_fsm.sv
// Control FSM for a two-register-top stack machine: fetch, execute, memory and
// interrupt sequencing, decoding datapath enables from state, opcode and mem_ready.
module stack_ctrl_fsm #(
  parameter int WIDTH    = 16,
  parameter bit MEM_WAIT = 1'b1,
  parameter bit IRQ_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ir,
  input  logic [2:0]       alu_flags,
  input  logic             irq,
  input  logic             mem_ready,
  output logic             read,
  output logic             write,
  output logic [1:0]       addr_sel,
  output logic [5:0]       alu_oper,
  output logic             data_from_alu,
  output logic             top_clken,
  output logic             top_from_next,
  output logic             next_clken,
  output logic             next_from_top,
  output logic             ir_clken,
  output logic             pc_clken,
  output logic             pc_load,
  output logic             dsp_clken,
  output logic             dsp_up,
  output logic             rsp_clken,
  output logic             rsp_up,
  output logic             iack,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_IRQ   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_ie;
  logic       w_ie_next;
  logic       w_to_fetch;
  logic       w_done;
  logic [3:0] w_op;
  logic       w_unused;

  assign w_op     = ir[WIDTH-1 -: 4];
  assign w_done   = MEM_WAIT ? mem_ready : 1'b1;
  assign w_unused = &{1'b0, ir, alu_flags, mem_ready};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ie    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ie    <= w_ie_next;
    end
  end

  always_comb begin
    read          = 1'b0;
    write         = 1'b0;
    addr_sel      = 2'd0;
    alu_oper      = 6'd0;
    data_from_alu = 1'b0;
    top_clken     = 1'b0;
    top_from_next = 1'b0;
    next_clken    = 1'b0;
    next_from_top = 1'b0;
    ir_clken      = 1'b0;
    pc_clken      = 1'b0;
    pc_load       = 1'b0;
    dsp_clken     = 1'b0;
    dsp_up        = 1'b0;
    rsp_clken     = 1'b0;
    rsp_up        = 1'b0;
    iack          = 1'b0;
    halted        = 1'b0;
    w_state_next  = r_state;
    w_ie_next     = r_ie;
    w_to_fetch    = 1'b0;

    // Reset forces every output low and abandons any memory cycle in flight.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          read = 1'b1;
          if (w_done) begin
            ir_clken     = 1'b1;
            pc_clken     = 1'b1;
            w_state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          w_to_fetch = 1'b1;
          case (w_op)
            4'h1: begin
              alu_oper      = ir[5:0];
              data_from_alu = 1'b1;
              top_clken     = 1'b1;
              w_to_fetch    = 1'b0;
              w_state_next  = S_MEM;
            end
            4'h2, 4'h3, 4'h4, 4'h5: begin
              w_to_fetch   = 1'b0;
              w_state_next = S_MEM;
            end
            4'h6: pc_load = alu_flags[1];
            4'h7: begin
              w_to_fetch   = 1'b0;
              w_state_next = S_HALT;
            end
            4'h8: begin
              if (IRQ_EN) begin
                w_to_fetch   = 1'b0;
                w_state_next = S_MEM;
              end
            end
            4'h9: if (IRQ_EN) w_ie_next = 1'b1;
            4'hA: if (IRQ_EN) w_ie_next = 1'b0;
            default: ;
          endcase
        end
        S_MEM: begin
          // The opcode in ir is still valid here since ir only loads in FETCH.
          case (w_op)
            4'h1: begin
              read       = 1'b1;
              addr_sel   = 2'd1;
              next_clken = w_done;
              dsp_clken  = w_done;
            end
            4'h2: begin
              read      = 1'b1;
              addr_sel  = 2'd3;
              top_clken = w_done;
            end
            4'h3: begin
              write         = 1'b1;
              addr_sel      = 2'd3;
              top_from_next = w_done;
              top_clken     = w_done;
              dsp_clken     = w_done;
            end
            4'h4: begin
              write     = 1'b1;
              addr_sel  = 2'd2;
              rsp_clken = w_done;
              rsp_up    = w_done;
              pc_load   = w_done;
            end
            4'h5, 4'h8: begin
              read      = 1'b1;
              addr_sel  = 2'd2;
              pc_load   = w_done;
              rsp_clken = w_done;
              if (w_op == 4'h8 && w_done) w_ie_next = 1'b1;
            end
            default: ;
          endcase
          w_to_fetch = w_done;
        end
        S_IRQ: begin
          write    = 1'b1;
          addr_sel = 2'd2;
          if (w_done) begin
            rsp_clken  = 1'b1;
            rsp_up     = 1'b1;
            pc_load    = 1'b1;
            alu_oper   = 6'b111111;
            iack       = 1'b1;
            w_ie_next  = 1'b0;
            w_to_fetch = 1'b1;
          end
        end
        S_HALT: begin
          halted = 1'b1;
          if (IRQ_EN && r_ie && irq) w_state_next = S_IRQ;
        end
        default: w_state_next = S_FETCH;
      endcase

      // The interrupt check uses the post-instruction ie so EI/RETI take effect at once.
      if (w_to_fetch) w_state_next = (IRQ_EN && w_ie_next && irq) ? S_IRQ : S_FETCH;
    end
  end

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Directed bench for stack_ctrl_fsm: expected output vectors are queued per step
// and compared against the packed DUT outputs mid-cycle.
module tb_stack_ctrl_fsm;

  logic        clk;
  logic        reset, reset0;
  logic [15:0] ir;
  logic [2:0]  alu_flags;
  logic        irq;
  logic        mem_ready, mem_ready0;

  logic        read, write, data_from_alu, top_clken, top_from_next, next_clken, next_from_top;
  logic        ir_clken, pc_clken, pc_load, dsp_clken, dsp_up, rsp_clken, rsp_up, iack, halted;
  logic [1:0]  addr_sel;
  logic [5:0]  alu_oper;
  logic        read0, write0, data_from_alu0, top_clken0, top_from_next0, next_clken0, next_from_top0;
  logic        ir_clken0, pc_clken0, pc_load0, dsp_clken0, dsp_up0, rsp_clken0, rsp_up0, iack0, halted0;
  logic [1:0]  addr_sel0;
  logic [5:0]  alu_oper0;

  logic [23:0] out_main, out0;

  localparam logic [23:0] RD    = 24'h800000;
  localparam logic [23:0] WR    = 24'h400000;
  localparam logic [23:0] AS1   = 24'h100000;
  localparam logic [23:0] AS2   = 24'h200000;
  localparam logic [23:0] AS3   = 24'h300000;
  localparam logic [23:0] DFA   = 24'd1 << 13;
  localparam logic [23:0] TOPC  = 24'd1 << 12;
  localparam logic [23:0] TFN   = 24'd1 << 11;
  localparam logic [23:0] NC    = 24'd1 << 10;
  localparam logic [23:0] IRC   = 24'd1 << 8;
  localparam logic [23:0] PCC   = 24'd1 << 7;
  localparam logic [23:0] PCL   = 24'd1 << 6;
  localparam logic [23:0] DSPC  = 24'd1 << 5;
  localparam logic [23:0] RSPC  = 24'd1 << 3;
  localparam logic [23:0] RSPUP = 24'd1 << 2;
  localparam logic [23:0] IACK  = 24'd1 << 1;
  localparam logic [23:0] HALTD = 24'd1;
  localparam logic [23:0] FETCHV = RD | IRC | PCC;
  localparam logic [23:0] IRQV  = WR | AS2 | RSPC | RSPUP | PCL | (24'h3F << 14) | IACK;

  stack_ctrl_fsm #(.WIDTH(16), .MEM_WAIT(1'b1), .IRQ_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ir(ir), .alu_flags(alu_flags), .irq(irq), .mem_ready(mem_ready),
    .read(read), .write(write), .addr_sel(addr_sel), .alu_oper(alu_oper),
    .data_from_alu(data_from_alu), .top_clken(top_clken), .top_from_next(top_from_next),
    .next_clken(next_clken), .next_from_top(next_from_top), .ir_clken(ir_clken),
    .pc_clken(pc_clken), .pc_load(pc_load), .dsp_clken(dsp_clken), .dsp_up(dsp_up),
    .rsp_clken(rsp_clken), .rsp_up(rsp_up), .iack(iack), .halted(halted)
  );

  stack_ctrl_fsm #(.WIDTH(16), .MEM_WAIT(1'b0), .IRQ_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset0), .ir(ir), .alu_flags(alu_flags), .irq(irq), .mem_ready(mem_ready0),
    .read(read0), .write(write0), .addr_sel(addr_sel0), .alu_oper(alu_oper0),
    .data_from_alu(data_from_alu0), .top_clken(top_clken0), .top_from_next(top_from_next0),
    .next_clken(next_clken0), .next_from_top(next_from_top0), .ir_clken(ir_clken0),
    .pc_clken(pc_clken0), .pc_load(pc_load0), .dsp_clken(dsp_clken0), .dsp_up(dsp_up0),
    .rsp_clken(rsp_clken0), .rsp_up(rsp_up0), .iack(iack0), .halted(halted0)
  );

  assign out_main = {read, write, addr_sel, alu_oper, data_from_alu, top_clken, top_from_next,
                     next_clken, next_from_top, ir_clken, pc_clken, pc_load, dsp_clken, dsp_up,
                     rsp_clken, rsp_up, iack, halted};
  assign out0     = {read0, write0, addr_sel0, alu_oper0, data_from_alu0, top_clken0, top_from_next0,
                     next_clken0, next_from_top0, ir_clken0, pc_clken0, pc_load0, dsp_clken0, dsp_up0,
                     rsp_clken0, rsp_up0, iack0, halted0};

  typedef struct {
    string       tag;
    logic [23:0] exp;
    bit          sel;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a falling edge with inputs set; compares mid-low-phase, then
  // advances to the next falling edge (one rising edge in between).
  task automatic chk(input string tag, input logic [23:0] e, input bit sel);
    exp_t        x;
    logic [23:0] obs;
    x.tag = tag;
    x.exp = e;
    x.sel = sel;
    sb.push_back(x);
    #2;
    x   = sb.pop_front();
    obs = x.sel ? out0 : out_main;
    tests++;
    assert (obs === x.exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; reset0 = 1'b1;
    ir = 16'h0000; alu_flags = 3'b000; irq = 1'b0;
    mem_ready = 1'b1; mem_ready0 = 1'b0;
    @(negedge clk);
    chk("reset", 24'h0, 0);
    reset = 1'b0;
    chk("fetch0", FETCHV, 0);
    chk("nop_exec", 24'h0, 0);
    chk("fetch1", FETCHV, 0);

    ir = 16'h2000;
    chk("ld_exec", 24'h0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) chk("ld_wait", RD | AS3, 0);
    mem_ready = 1'b1;
    chk("ld_done", RD | AS3 | TOPC, 0);
    chk("fetch_ld", FETCHV, 0);

    ir = 16'h6000; alu_flags = 3'b010;
    chk("jz_taken", PCL, 0);
    chk("fetch_jz", FETCHV, 0);
    alu_flags = 3'b000;
    chk("jz_not", 24'h0, 0);
    chk("fetch_jz2", FETCHV, 0);

    ir = 16'h1015;
    chk("alu_exec", (24'h15 << 14) | DFA | TOPC, 0);
    chk("alu_refill", RD | AS1 | NC | DSPC, 0);
    chk("fetch_alu", FETCHV, 0);

    ir = 16'h3000;
    chk("st_exec", 24'h0, 0);
    chk("st_mem", WR | AS3 | TFN | TOPC | DSPC, 0);
    chk("fetch_st", FETCHV, 0);

    ir = 16'h4000;
    chk("call_exec", 24'h0, 0);
    mem_ready = 1'b0;
    chk("call_wait", WR | AS2, 0);
    mem_ready = 1'b1;
    chk("call_done", WR | AS2 | RSPC | RSPUP | PCL, 0);
    chk("fetch_call", FETCHV, 0);

    ir = 16'h5000;
    chk("ret_exec", 24'h0, 0);
    chk("ret_mem", RD | AS2 | PCL | RSPC, 0);
    chk("fetch_ret", FETCHV, 0);

    ir = 16'h9000; irq = 1'b1;
    chk("ei_exec", 24'h0, 0);
    mem_ready = 1'b0;
    chk("irq_wait", WR | AS2, 0);
    mem_ready = 1'b1;
    chk("irq_ack", IRQV, 0);
    chk("fetch_after_irq", FETCHV, 0);
    ir = 16'h0000;
    chk("nop_irq_held", 24'h0, 0);
    chk("fetch_no_reack", FETCHV, 0);
    ir = 16'h8000;
    chk("reti_exec", 24'h0, 0);
    chk("reti_mem", RD | AS2 | PCL | RSPC, 0);
    irq = 1'b0;
    chk("irq_after_reti", IRQV, 0);
    chk("fetch_after_irq2", FETCHV, 0);

    ir = 16'h9000;
    chk("ei2_exec", 24'h0, 0);
    chk("fetch_ei2", FETCHV, 0);
    ir = 16'hA000; irq = 1'b1;
    chk("di_exec", 24'h0, 0);
    chk("fetch_di", FETCHV, 0);
    ir = 16'h7000;
    chk("halt_exec", 24'h0, 0);
    for (int i = 0; i < 20; i++) chk("halt_ie0", HALTD, 0);

    reset = 1'b1; irq = 1'b0;
    chk("reset2", 24'h0, 0);
    reset = 1'b0;
    chk("fetch_r2", FETCHV, 0);
    ir = 16'h2000;
    chk("ld2_exec", 24'h0, 0);
    mem_ready = 1'b0;
    chk("ld2_wait", RD | AS3, 0);
    reset = 1'b1; mem_ready = 1'b1;
    chk("rst_mid_mem", 24'h0, 0);
    reset = 1'b0;
    chk("fetch_r3", FETCHV, 0);
    ir = 16'h9000;
    chk("ei3_exec", 24'h0, 0);
    chk("fetch_ei3", FETCHV, 0);
    ir = 16'h7000;
    chk("halt2_exec", 24'h0, 0);
    chk("halt_wait", HALTD, 0);
    irq = 1'b1;
    chk("halt_irq", HALTD, 0);
    chk("irq_from_halt", IRQV, 0);
    irq = 1'b0;
    chk("fetch_after_halt", FETCHV, 0);

    chk("d0_reset", 24'h0, 1);
    reset0 = 1'b0; ir = 16'h4000;
    chk("d0_fetch", FETCHV, 1);
    chk("d0_call_exec", 24'h0, 1);
    chk("d0_call_mem", WR | AS2 | RSPC | RSPUP | PCL, 1);
    chk("d0_fetch_after", FETCHV, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
